gate_sweep_ctrl: RTL

//  Sequencer that exhaustively drives an N-input switch-level gate under test (e.g. the pmos AND3 cell).

---
 rtl/gate_sweep_ctrl_if.sv | 41 ++++
 rtl/gate_sweep_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gate_sweep_ctrl_if                                           |
// | Description : Bundles the control, gate-drive and result signals of        |
// |               gate_sweep_ctrl. The slave modport is the sequencer view.    |
// |               The master modport is the bench and gate view.               |
// | Signals     : start, abort, y_in      -> sequencer                         |
// |               x_out, busy, vec_valid, vec_idx, vec_ok, done, pass,         |
// |               fail_cnt, fail_idx, y_log <- sequencer                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface gate_sweep_ctrl_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 abort;
   logic                 y_in;
   logic [N_IN-1:0]      x_out;
   logic                 busy;
   logic                 vec_valid;
   logic [N_IN-1:0]      vec_idx;
   logic                 vec_ok;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        fail_cnt;
   logic [N_IN-1:0]      fail_idx;
   logic [2**N_IN-1:0]   y_log;

   modport slave (
      input  start, abort, y_in,
      output x_out, busy, vec_valid, vec_idx, vec_ok, done, pass,
             fail_cnt, fail_idx, y_log
   );

   modport master (
      output start, abort, y_in,
      input  x_out, busy, vec_valid, vec_idx, vec_ok, done, pass,
             fail_cnt, fail_idx, y_log
   );
endinterface
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gate_sweep_ctrl                                              |
// | Description : Exhaustive sweep sequencer for an N_IN-input gate under      |
// |               test. It drives every input vector in turn and holds each    |
// |               one for SETTLE_CYC cycles. It then samples the synchronised  |
// |               gate output, compares it with TRUTH and accumulates the      |
// |               per-sweep result.                                            |
// | Ports       : clk, rst (async, active-high)                                |
// |               sweep.start/abort    - sweep control                         |
// |               sweep.y_in           - gate output (asynchronous)            |
// |               sweep.x_out          - registered gate input drive           |
// |               sweep.busy/done/pass - sweep status                          |
// |               sweep.vec_*          - per-vector result strobe              |
// |               sweep.fail_cnt/fail_idx/y_log - accumulated results          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gate_sweep_ctrl #(
   parameter int                  N_IN       = 3,
   parameter int                  SETTLE_CYC = 5,
   parameter logic [2**N_IN-1:0]  TRUTH      = 8'h80
) (
   input  wire logic          clk,
   input  wire logic          rst,
   gate_sweep_ctrl_if.slave   sweep
);

   localparam int              c_NUM_VEC  = 2**N_IN;
   localparam int              c_CNT_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [N_IN-1:0] c_LAST_IDX = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                 state_q,     state_d;
   logic [N_IN-1:0]        idx_q,       idx_d;
   logic [c_CNT_W-1:0]     cnt_q,       cnt_d;
   logic [N_IN-1:0]        x_q,         x_d;
   logic                   busy_q,      busy_d;
   logic                   vec_valid_q, vec_valid_d;
   logic [N_IN-1:0]        vec_idx_q,   vec_idx_d;
   logic                   vec_ok_q,    vec_ok_d;
   logic                   done_q,      done_d;
   logic                   pass_q,      pass_d;
   logic [N_IN:0]          fail_cnt_q,  fail_cnt_d;
   logic [N_IN-1:0]        fail_idx_q,  fail_idx_d;
   logic [c_NUM_VEC-1:0]   y_log_q,     y_log_d;
   logic [1:0]             ysync_q;

   logic                   w_y_s;
   logic                   w_mismatch;

   // Two-flop synchroniser for the asynchronous gate output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ysync_q <= 2'b00;
      end else begin
         ysync_q <= {ysync_q[0], sweep.y_in};
      end
   end

   assign w_y_s = ysync_q[1];
   // Case inequality so that an X or Z on the gate output is a mismatch.
   assign w_mismatch = (w_y_s !== TRUTH[idx_q]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         x_q         <= '0;
         busy_q      <= 1'b0;
         vec_valid_q <= 1'b0;
         vec_idx_q   <= '0;
         vec_ok_q    <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_cnt_q  <= '0;
         fail_idx_q  <= '0;
         y_log_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         busy_q      <= busy_d;
         vec_valid_q <= vec_valid_d;
         vec_idx_q   <= vec_idx_d;
         vec_ok_q    <= vec_ok_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_idx_q  <= fail_idx_d;
         y_log_q     <= y_log_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      busy_d      = busy_q;
      vec_valid_d = 1'b0;
      vec_idx_d   = vec_idx_q;
      vec_ok_d    = vec_ok_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      fail_cnt_d  = fail_cnt_q;
      fail_idx_d  = fail_idx_q;
      y_log_d     = y_log_q;

      case (state_q)
         ST_IDLE: begin
            x_d    = '0;
            busy_d = 1'b0;
            // Results of the previous sweep stay visible until a new start.
            if (sweep.start && !sweep.abort) begin
               state_d    = ST_SETTLE;
               idx_d      = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               fail_cnt_d = '0;
               fail_idx_d = '0;
               y_log_d    = '0;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == c_CNT_W'(SETTLE_CYC - 1)) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_SAMPLE: begin
            y_log_d[idx_q] = w_y_s;
            vec_valid_d    = 1'b1;
            vec_idx_d      = idx_q;
            vec_ok_d       = !w_mismatch;
            if (w_mismatch) begin
               fail_cnt_d = fail_cnt_q + 1'b1;
               if (fail_cnt_q == '0) begin
                  fail_idx_d = idx_q;
               end
            end
            if (idx_q == c_LAST_IDX) begin
               // x_out keeps the last vector through DONE.
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (fail_cnt_d == '0);
            end else begin
               state_d = ST_SETTLE;
               idx_d   = idx_q + 1'b1;
               x_d     = idx_q + 1'b1;
               cnt_d   = '0;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            x_d     = '0;
         end

         default: begin
            state_d = ST_IDLE;
            x_d     = '0;
            busy_d  = 1'b0;
         end
      endcase

      // Abort wins over every other action, including the sample update,
      // so the partial results reflect only vectors completed before it.
      if (sweep.abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         idx_d       = idx_q;
         cnt_d       = '0;
         x_d         = '0;
         busy_d      = 1'b0;
         vec_valid_d = 1'b0;
         vec_idx_d   = vec_idx_q;
         vec_ok_d    = vec_ok_q;
         done_d      = 1'b0;
         pass_d      = 1'b0;
         fail_cnt_d  = fail_cnt_q;
         fail_idx_d  = fail_idx_q;
         y_log_d     = y_log_q;
      end
   end

   assign sweep.x_out     = x_q;
   assign sweep.busy      = busy_q;
   assign sweep.vec_valid = vec_valid_q;
   assign sweep.vec_idx   = vec_idx_q;
   assign sweep.vec_ok    = vec_ok_q;
   assign sweep.done      = done_q;
   assign sweep.pass      = pass_q;
   assign sweep.fail_cnt  = fail_cnt_q;
   assign sweep.fail_idx  = fail_idx_q;
   assign sweep.y_log     = y_log_q;

endmodule
`default_nettype wire
